fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 0, word index fetched first after reset.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, number of instruction-memory words (power of two).
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pc  output  32  word index to instruction memory; memory read is combinational.
REQ-006 SHALL have port mem_inst  input  32  instruction word returned for pc in the same cycle.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-008 SHALL have port redirect_pc  input  32  word-index target of the redirect.
REQ-009 SHALL have port out_valid  output  1  out_inst/out_pc hold a fetched instruction.
REQ-010 SHALL have port out_ready  input  1  decode accepts out_* this cycle.
REQ-011 SHALL have port out_inst  output  32  fetched instruction (IF/ID register).
REQ-012 SHALL have port out_pc  output  32  word index of out_inst.
REQ-013 SHALL have port halted  output  1  fetch stopped on an empty memory word.
REQ-014 SHALL have port resume  input  1  leave HALT and retry the held pc.

Function
REQ-015 SHALL implement states RUN and HALT; halted = (state == HALT).
REQ-016 SHALL define load = RUN && (!out_valid || out_ready); handshake transfer = out_valid && out_ready.
REQ-017 On load without redirect and mem_inst != 0: out_inst<=mem_inst, out_pc<=pc, out_valid<=1, pc<=(pc+1) mod MEM_DEPTH; latency one cycle.
REQ-018 When out_valid && !out_ready: pc, out_inst, out_pc, out_valid SHALL hold unchanged (stall).
REQ-019 Transfer without load-eligible new word SHALL clear out_valid.
REQ-020 Redirect SHALL have highest priority in any state: pc<=redirect_pc mod MEM_DEPTH, out_valid<=0 (flush, regardless of out_ready), state<=RUN.
REQ-021 On load with mem_inst == 32'h0 and no redirect: word not delivered, out_valid<=0, pc held, state<=HALT.
REQ-022 In HALT: no fetch, pc held, out_valid 0; resume (no redirect) SHALL return to RUN, refetching same pc next cycle.
REQ-023 pc upper bits above log2(MEM_DEPTH) SHALL always be zero; MEM_DEPTH-1 increments to 0.

Reset
REQ-024 reset_n low SHALL immediately force pc=RESET_PC, out_valid=0, out_inst=32'h00000013 (NOP), out_pc=0, state=RUN, counters=0.
REQ-025 Reset asserted mid-stall or mid-HALT SHALL discard the held instruction; first fetch occurs on the first rising edge after deassertion.

Configuration
REQ-026 Macro FETCH_PERF_EN SHALL add outputs perf_fetch_count (32, increments per REQ-017 load) and perf_stall_count (32, increments per REQ-018 cycle), both saturating at 32'hFFFFFFFF.
REQ-027 Without FETCH_PERF_EN those ports and counters SHALL be absent; remaining behaviour identical.

Structure
REQ-028 Shared package riscv_pkg SHALL hold INST_NOP, MEM_DEPTH default, and the fetch state enum.
REQ-029 One sub-module fetch_perf_counter (saturating 32-bit counter) SHALL be instantiated twice under FETCH_PERF_EN; PC, IF/ID register and FSM stay in fetch_stage.

Verification
REQ-030 Reset release, memory[0]=32'h00100113, [1]=32'h00200093, out_ready=1 -> cycle 1 out_inst=32'h00100113/out_pc=0, cycle 2 32'h00200093/out_pc=1, pc=2.
REQ-031 out_ready=0 for 3 cycles with out_valid=1 -> out_*, pc unchanged; perf_stall_count=3; first word after release is next sequential.
REQ-032 redirect_valid=1, redirect_pc=12 while stalled -> next cycle out_valid=0, pc=12; following cycle out_pc=12, out_inst=memory[12].
REQ-033 pc reaches 7 with memory[7]=0 -> out_valid=0, halted=1, pc=7 held; resume after memory[7] written -> halted=0, out_pc=7 delivered.
REQ-034 pc=255, MEM_DEPTH=256 -> next pc=0; redirect_pc=32'h00000105 -> pc=5.
REQ-035 reset_n low during HALT with pc=9 -> halted=0, pc=RESET_PC, out_valid=0 asynchronously.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: NOP encoding, default memory depth and the fetch state enum.
package riscv_pkg;
   localparam logic [31:0] INST_NOP          = 32'h0000_0013;
   localparam int unsigned MEM_DEPTH_DEFAULT = 256;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;
endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating 32-bit event counter, built only with FETCH_PERF_EN; one cycle to count, sticks at all-ones.
`ifdef FETCH_PERF_EN
module fetch_perf_counter (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_inc,
   output logic [31:0] o_count
);
   logic [31:0] r_count;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count <= 32'd0;
      end else if (i_inc && (r_count != 32'hFFFF_FFFF)) begin
         r_count <= r_count + 32'd1;
      end
   end

   assign o_count = r_count;
endmodule
`endif

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register: one-cycle latency, holds on !out_ready, halts on an all-zero word.
// Redirects flush and win in any state. FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic [31:0] pc,
   input  logic [31:0] mem_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        halted,
`ifdef FETCH_PERF_EN
   output logic [31:0] perf_fetch_count,
   output logic [31:0] perf_stall_count,
`endif
   input  logic        resume
);
   // Word-index wrap mask; upper pc bits stay zero because every pc write goes through it.
   localparam logic [31:0] PC_MASK = 32'(MEM_DEPTH - 1);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   logic [31:0]  r_pc;
   logic         r_out_valid;
   logic [31:0]  r_out_inst;
   logic [31:0]  r_out_pc;
   logic         w_load;
   logic         w_fetch;
   logic         w_empty_word;

   assign w_empty_word = (mem_inst == 32'h0);
   assign w_load       = (r_state == RUN) && (!r_out_valid || out_ready);
   assign w_fetch      = w_load && !redirect_valid && !w_empty_word;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (redirect_valid) begin
         w_state_nxt = RUN;
      end else if (r_state == HALT) begin
         if (resume) begin
            w_state_nxt = RUN;
         end
      end else if (w_load && w_empty_word) begin
         w_state_nxt = HALT;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pc        <= RESET_PC & PC_MASK;
         r_out_valid <= 1'b0;
         r_out_inst  <= INST_NOP;
         r_out_pc    <= 32'd0;
      end else if (redirect_valid) begin
         r_pc        <= redirect_pc & PC_MASK;
         r_out_valid <= 1'b0;
      end else if (w_fetch) begin
         r_out_inst  <= mem_inst;
         r_out_pc    <= r_pc;
         r_out_valid <= 1'b1;
         r_pc        <= (r_pc + 32'd1) & PC_MASK;
      end else if (w_load) begin
         // Empty word: drop it and keep pc so resume retries the same index.
         r_out_valid <= 1'b0;
      end
   end

   assign pc        = r_pc;
   assign out_valid = r_out_valid;
   assign out_inst  = r_out_inst;
   assign out_pc    = r_out_pc;
   assign halted    = (r_state == HALT);

`ifdef FETCH_PERF_EN
   logic w_stall;
   assign w_stall = r_out_valid && !out_ready && !redirect_valid;

   fetch_perf_counter u_fetch_cnt (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_inc     (w_fetch),
      .o_count   (perf_fetch_count)
   );

   fetch_perf_counter u_stall_cnt (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_inc     (w_stall),
      .o_count   (perf_stall_count)
   );
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic against a slot/queue reference model;
// a separate monitor checks every decode handshake against the expected-delivery queue.
module tb_fetch_stage;
   import riscv_pkg::*;

   localparam int          DEPTH  = 256;
   localparam logic [31:0] RST_PC = 32'd0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } item_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] pc;
   logic [31:0] mem_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        halted;
   logic        resume;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_count;
   logic [31:0] perf_stall_count;
   logic [31:0] stall_base;
`endif

   logic [31:0] mem [DEPTH];
   assign mem_inst = mem[pc[7:0]];

   always #5 clock = ~clock;

   fetch_stage #(.RESET_PC(RST_PC), .MEM_DEPTH(DEPTH)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .pc             (pc),
      .mem_inst       (mem_inst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .halted         (halted),
`ifdef FETCH_PERF_EN
      .perf_fetch_count (perf_fetch_count),
      .perf_stall_count (perf_stall_count),
`endif
      .resume         (resume)
   );

   // Reference model: one-entry output slot, a fetch pointer and a halt flag.
   item_t       slot[$];
   item_t       exp_q[$];
   item_t       mon_it;
   logic [31:0] m_pc;
   logic        m_halt;
   logic [31:0] m_fetches;
   logic [31:0] m_stalls;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] saved_pc;
   logic [31:0] saved_opc;
   bit          seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      slot.delete();
      exp_q.delete();
      m_pc      = RST_PC % 32'(DEPTH);
      m_halt    = 1'b0;
      m_fetches = 32'd0;
      m_stalls  = 32'd0;
   endtask

   task automatic model_step();
      item_t it;
      if (!redirect_valid && slot.size() != 0 && out_ready) exp_q.push_back(slot.pop_front());
      if (redirect_valid) begin
         slot.delete();
         m_pc   = redirect_pc % 32'(DEPTH);
         m_halt = 1'b0;
      end else if (m_halt) begin
         if (resume) m_halt = 1'b0;
      end else if (slot.size() != 0) begin
         m_stalls++;
      end else if (mem[m_pc[7:0]] == 32'h0) begin
         m_halt = 1'b1;
      end else begin
         it.pc   = m_pc;
         it.inst = mem[m_pc[7:0]];
         slot.push_back(it);
         m_pc = (m_pc + 32'd1) % 32'(DEPTH);
         m_fetches++;
      end
   endtask

   task automatic state_check();
      check("pc", pc, m_pc);
      check("halted", 32'(halted), 32'(m_halt));
      check("out_valid", 32'(out_valid), 32'(slot.size() != 0));
      if (slot.size() != 0) begin
         check("out_pc", out_pc, slot[0].pc);
         check("out_inst", out_inst, slot[0].inst);
      end
`ifdef FETCH_PERF_EN
      check("perf_fetch", perf_fetch_count, m_fetches);
      check("perf_stall", perf_stall_count, m_stalls);
`endif
   endtask

   // Called right after a negedge with inputs already driven; returns at the next negedge.
   task automatic cycle();
      #1;
      state_check();
      model_step();
      @(negedge clock);
   endtask

   initial begin
      forever begin
         @(negedge clock);
         #2;
         if (reset_n && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL scoreboard: handshake of pc %h with nothing expected", out_pc);
            end else begin
               mon_it = exp_q.pop_front();
               check("sb_pc", out_pc, mon_it.pc);
               check("sb_inst", out_inst, mon_it.inst);
            end
         end
      end
   end

   initial begin
      reset_n        = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      resume         = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom | 32'h1;
      mem[0] = 32'h0010_0113;
      mem[1] = 32'h0020_0093;
      model_reset();

      @(negedge clock);
      #1;
      check("rst_pc", pc, RST_PC);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_inst", out_inst, 32'h0000_0013);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_EN
      check("rst_perf_fetch", perf_fetch_count, 32'd0);
      check("rst_perf_stall", perf_stall_count, 32'd0);
`endif

      // Reset release, two sequential words
      @(negedge clock);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      cycle();
      check("first_inst", out_inst, 32'h0010_0113);
      check("first_pc", out_pc, 32'd0);
      cycle();
      check("second_inst", out_inst, 32'h0020_0093);
      check("second_pc", out_pc, 32'd1);
      check("second_next_pc", pc, 32'd2);

      // Three-cycle stall
      out_ready = 1'b0;
      saved_pc  = pc;
      saved_opc = out_pc;
`ifdef FETCH_PERF_EN
      stall_base = perf_stall_count;
`endif
      for (int i = 0; i < 3; i++) cycle();
      check("stall_pc_hold", pc, saved_pc);
      check("stall_out_pc_hold", out_pc, saved_opc);
`ifdef FETCH_PERF_EN
      check("stall_count3", perf_stall_count - stall_base, 32'd3);
`endif
      out_ready = 1'b1;
      cycle();
      check("after_stall_seq", out_pc, saved_opc + 32'd1);

      // Redirect while stalled
      out_ready = 1'b0;
      cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'd12;
      cycle();
      redirect_valid = 1'b0;
      check("redir_flush", 32'(out_valid), 32'd0);
      check("redir_pc", pc, 32'd12);
      out_ready = 1'b1;
      cycle();
      check("redir_out_pc", out_pc, 32'd12);
      check("redir_out_inst", out_inst, mem[12]);

      // Halt on empty word at 7, then resume
      mem[7]         = 32'h0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'd5;
      cycle();
      redirect_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         cycle();
         seen = halted;
      end
      check("halt_reached", 32'(seen), 32'd1);
      for (int i = 0; i < 3; i++) cycle();
      check("halt_pc_hold", pc, 32'd7);
      check("halt_no_valid", 32'(out_valid), 32'd0);
      mem[7] = 32'h0070_0393;
      resume = 1'b1;
      cycle();
      resume = 1'b0;
      check("resume_run", 32'(halted), 32'd0);
      cycle();
      check("resume_out_pc", out_pc, 32'd7);
      check("resume_valid", 32'(out_valid), 32'd1);

      // pc wrap and redirect modulo depth
      redirect_valid = 1'b1;
      redirect_pc    = 32'd255;
      cycle();
      redirect_valid = 1'b0;
      cycle();
      check("wrap_pc", pc, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0105;
      cycle();
      redirect_valid = 1'b0;
      check("redir_mod_pc", pc, 32'd5);

      // Asynchronous reset while halted at 9
      mem[9]         = 32'h0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'd9;
      cycle();
      redirect_valid = 1'b0;
      cycle();
      check("halt9", 32'(halted), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check("arst_halted", 32'(halted), 32'd0);
      check("arst_pc", pc, RST_PC);
      check("arst_valid", 32'(out_valid), 32'd0);
      model_reset();
      mem[9] = 32'h0090_0493;
      @(negedge clock);
      reset_n = 1'b1;

      // Random traffic, with some empty words sprinkled in
      for (int i = 2; i < DEPTH; i++) if ($urandom_range(0, 15) == 0) mem[i] = 32'h0;
      for (int c = 0; c < 800; c++) begin
         out_ready      = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc    = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
         resume         = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0)
            mem[$urandom_range(0, DEPTH - 1)] = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h1);
         cycle();
      end
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      resume         = 1'b0;
      #3;
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
